// File: rtl/tm1638_keyscan.sv
// tm1638_keyscan -- TM1638 key-scan reader.
//
// Requests the shared TM1638 pins, sends the "read key data" command (0x42),
// turns DIO around and shifts in the four key-scan bytes, then publishes them
// as a 32-bit key image.
//
// Optional feature: define TM1638_KEYSCAN_AUTOPOLL_EN to add a free-running
// poll counter that issues an internal scan request every POLL_CYCLES clocks.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   start         single-cycle scan request (ignored unless idle)
//   bus_req       pin request to the arbiter; bus_gnt = pins granted
//   tm_clk        TM1638 CLK
//   tm_stb        TM1638 STB, active low
//   tm_dio_out    DIO drive value; tm_dio_oe = DIO drive enable
//   tm_dio_in     DIO pin value, already synchronised
//   keys          last completed scan, byte n in keys[8n+7:8n]
//   keys_valid    one-cycle pulse when keys updates
//   keys_changed  one-cycle pulse with keys_valid when the image changed
//   busy          high from request until back in idle
module tm1638_keyscan #(
  parameter int unsigned HALF_DIV    = 16,
  parameter int unsigned WAIT_HALVES = 4,
  parameter int unsigned POLL_CYCLES = 160000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        tm_clk,
  output logic        tm_stb,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic        tm_dio_in,
  output logic [31:0] keys,
  output logic        keys_valid,
  output logic        keys_changed,
  output logic        busy
);

  localparam logic [7:0]        READ_CMD  = 8'h42;
  localparam int unsigned       DIV_W     = 8;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam int unsigned       WAIT_W    = (WAIT_HALVES > 1) ? $clog2(WAIT_HALVES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_HALVES - 1);

  if (HALF_DIV < 2 || HALF_DIV > 255) begin : g_chk_div
    $error("tm1638_keyscan: HALF_DIV must be within 2..255");
  end
  if (WAIT_HALVES < 1) begin : g_chk_wait
    $error("tm1638_keyscan: WAIT_HALVES must be at least 1");
  end
  if (POLL_CYCLES < 2) begin : g_chk_poll
    $error("tm1638_keyscan: POLL_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STB_LO,
    S_CMD,
    S_WAIT,
    S_READ,
    S_STB_HI,
    S_DONE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [5:0]          bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [31:0]         shift;
  logic                tick;
  logic                poll_tick;
  logic                go;

  assign tick = (div_cnt == DIV_LAST);
  assign go   = start | poll_tick;

`ifdef TM1638_KEYSCAN_AUTOPOLL_EN
  localparam int unsigned       POLL_W    = $clog2(POLL_CYCLES);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);

  logic [POLL_W-1:0] poll_cnt;

  // Free-running: keeps counting during a scan; a tick that lands while
  // busy is simply not seen by the idle state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign poll_tick = (poll_cnt == POLL_LAST);
`else
  assign poll_tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      shift        <= '0;
      bus_req      <= 1'b0;
      tm_clk       <= 1'b1;
      tm_stb       <= 1'b1;
      tm_dio_out   <= 1'b1;
      tm_dio_oe    <= 1'b0;
      keys         <= '0;
      keys_valid   <= 1'b0;
      keys_changed <= 1'b0;
      busy         <= 1'b0;
    end else begin
      keys_valid   <= 1'b0;
      keys_changed <= 1'b0;

      // Half-period divider only runs while the pins are owned.
      if (state inside {S_IDLE, S_REQ, S_DONE} || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_REQ;
            bus_req <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_REQ: begin
          if (bus_gnt) begin
            state     <= S_STB_LO;
            tm_stb    <= 1'b0;
            tm_clk    <= 1'b1;
            tm_dio_oe <= 1'b1;
          end
        end

        S_STB_LO: begin
          if (tick) begin
            state      <= S_CMD;
            tm_clk     <= 1'b0;
            tm_dio_out <= READ_CMD[0];
            bit_cnt    <= '0;
          end
        end

        // tm_clk doubles as the half-phase flag: low half then high half.
        S_CMD: begin
          if (tick) begin
            if (!tm_clk) begin
              tm_clk <= 1'b1;
            end else if (bit_cnt == 6'd7) begin
              state      <= S_WAIT;
              tm_dio_oe  <= 1'b0;
              tm_dio_out <= 1'b1;
              wait_cnt   <= '0;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              tm_clk     <= 1'b0;
              tm_dio_out <= READ_CMD[bit_cnt[2:0] + 3'd1];
            end
          end
        end

        S_WAIT: begin
          if (tick) begin
            if (wait_cnt == WAIT_LAST) begin
              state   <= S_READ;
              tm_clk  <= 1'b0;
              bit_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        // Sample on the rising CLK edge; right shift lands bit k in shift[k].
        S_READ: begin
          if (tick) begin
            if (!tm_clk) begin
              tm_clk <= 1'b1;
              shift  <= {tm_dio_in, shift[31:1]};
            end else if (bit_cnt == 6'd31) begin
              state  <= S_STB_HI;
              tm_stb <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tm_clk  <= 1'b0;
            end
          end
        end

        S_STB_HI: begin
          if (tick) begin
            state        <= S_DONE;
            keys         <= shift;
            keys_valid   <= 1'b1;
            keys_changed <= (shift != keys);
            bus_req      <= 1'b0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_keyscan.sv
// Testbench for tm1638_keyscan: timeline model of one scan (position in the
// transaction -> expected pin levels), a TM1638 device model returning
// dev_data, and directed scan scenarios.
module tb_tm1638_keyscan;

  localparam int unsigned H     = 16;
  localparam int unsigned W     = 4;
  localparam int unsigned POLL  = 2000;
  localparam int unsigned TOTAL = (82 + W) * H;
  localparam logic [7:0]  CMD_BYTE = 8'h42;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic        bus_gnt   = 1'b0;
  logic        tm_dio_in = 1'b1;
  logic        bus_req;
  logic        tm_clk;
  logic        tm_stb;
  logic        tm_dio_out;
  logic        tm_dio_oe;
  logic [31:0] keys;
  logic        keys_valid;
  logic        keys_changed;
  logic        busy;

  logic [31:0] dev_data = '0;
  logic [4:0]  rd_idx   = '0;

  int n_checks = 0;
  int n_err    = 0;

  tm1638_keyscan #(
    .HALF_DIV    (H),
    .WAIT_HALVES (W),
    .POLL_CYCLES (POLL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus_req      (bus_req),
    .bus_gnt      (bus_gnt),
    .tm_clk       (tm_clk),
    .tm_stb       (tm_stb),
    .tm_dio_out   (tm_dio_out),
    .tm_dio_oe    (tm_dio_oe),
    .tm_dio_in    (tm_dio_in),
    .keys         (keys),
    .keys_valid   (keys_valid),
    .keys_changed (keys_changed),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // TM1638 device: presents the next key bit after each falling CLK once DIO
  // has been released; restarts at bit 0 when STB goes high.
  always @(negedge tm_clk or posedge tm_stb) begin
    if (tm_stb) begin
      rd_idx = '0;
    end else if (!tm_dio_oe) begin
      tm_dio_in = dev_data[rd_idx];
      rd_idx    = rd_idx + 5'd1;
    end
  end

  // Behavioural model: idle / requesting / active with m_n = cycles since
  // the clock edge that accepted the grant. Publication at m_n == TOTAL.
  typedef enum {M_IDLE, M_REQ, M_ACT} mmode_t;
  mmode_t      m_mode    = M_IDLE;
  int unsigned m_n       = 0;
  logic [31:0] m_keys    = '0;
  logic        m_changed = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode    = M_IDLE;
      m_n       = 0;
      m_keys    = '0;
      m_changed = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) m_mode = M_REQ;
        M_REQ: begin
          if (bus_gnt) begin
            m_mode = M_ACT;
            m_n    = 0;
          end
        end
        default: begin
          if (m_n == TOTAL) begin
            m_mode = M_IDLE;
          end else begin
            m_n = m_n + 1;
            if (m_n == TOTAL) begin
              m_changed = (dev_data != m_keys);
              m_keys    = dev_data;
            end
          end
        end
      endcase
    end
  end

`ifndef TM1638_KEYSCAN_AUTOPOLL_EN
  always @(negedge clk) begin
    logic        e_req, e_busy, e_clk, e_stb, e_oe, e_val, e_chg, e_dio, dio_known;
    int unsigned h, c, r;
    e_req = 1'b0; e_busy = 1'b0; e_clk = 1'b1; e_stb = 1'b1; e_oe = 1'b0;
    e_val = 1'b0; e_chg = 1'b0; e_dio = 1'b1; dio_known = 1'b1;
    h = 0; c = 0; r = 0;
    case (m_mode)
      M_REQ: begin
        e_req  = 1'b1;
        e_busy = 1'b1;
      end
      M_ACT: begin
        e_busy    = 1'b1;
        dio_known = 1'b0;
        if (m_n == TOTAL) begin
          e_val = 1'b1;
          e_chg = m_changed;
        end else begin
          e_req = 1'b1;
          h = m_n / H;
          if (h == 0) begin
            e_stb = 1'b0;
            e_oe  = 1'b1;
          end else if (h <= 16) begin
            c         = h - 1;
            e_stb     = 1'b0;
            e_oe      = 1'b1;
            e_clk     = c[0];
            e_dio     = CMD_BYTE[c >> 1];
            dio_known = 1'b1;
          end else if (h <= 16 + W) begin
            e_stb = 1'b0;
          end else if (h <= 80 + W) begin
            r     = h - 17 - W;
            e_stb = 1'b0;
            e_clk = r[0];
          end
        end
      end
      default: ;
    endcase
    check1("bus_req", bus_req, e_req);
    check1("busy", busy, e_busy);
    check1("tm_clk", tm_clk, e_clk);
    check1("tm_stb", tm_stb, e_stb);
    check1("tm_dio_oe", tm_dio_oe, e_oe);
    check1("keys_valid", keys_valid, e_val);
    check1("keys_changed", keys_changed, e_chg);
    check32("keys", keys, m_keys);
    if (dio_known) check1("tm_dio_out", tm_dio_out, e_dio);
  end
`endif

  // One scan with a cooperative arbiter; optionally pulses start again at
  // cycle poke_at after the grant.
  task automatic run_scan(input int gnt_delay, input int poke_at,
                          output int lat, output int nvalid, output logic chg,
                          output logic [7:0] cmd_cap, output int busy_gaps);
    int   k;
    int   ncap;
    logic prev_clk;
    lat = -1; nvalid = 0; chg = 1'b0; cmd_cap = '0; busy_gaps = 0; ncap = 0; k = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (gnt_delay) @(negedge clk);
    bus_gnt  = 1'b1;
    prev_clk = tm_clk;
    while (bus_req && k < 3000) begin
      @(negedge clk);
      k++;
      start = (k == poke_at);
      if (keys_valid) begin
        nvalid++;
        lat = k - 1;
        chg = keys_changed;
      end
      if (!busy) busy_gaps++;
      if (!prev_clk && tm_clk && tm_dio_oe && ncap < 8) begin
        cmd_cap[ncap] = tm_dio_out;
        ncap++;
      end
      prev_clk = tm_clk;
    end
    bus_gnt = 1'b0;
    start   = 1'b0;
    check1("scan_completed_in_budget", (k < 3000), 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int         lat, nv, gaps, rises;
    logic       chg;
    logic [7:0] cap;
    logic       prev_req;
    int         rise_at[$];

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check1("idle_bus_req", bus_req, 1'b0);
    check1("idle_tm_stb", tm_stb, 1'b1);
    check32("idle_keys", keys, 32'h0);

`ifndef TM1638_KEYSCAN_AUTOPOLL_EN
    dev_data = 32'h84002001;
    run_scan(50, 0, lat, nv, chg, cap, gaps);
    check32("scan1_keys", keys, 32'h84002001);
    check32("scan1_latency", lat, 32'd1376);
    check32("scan1_valid_pulses", nv, 32'd1);
    check1("scan1_changed", chg, 1'b1);
    check32("scan1_cmd_bits", {24'h0, cap}, 32'h42);

    run_scan(5, 0, lat, nv, chg, cap, gaps);
    check32("scan2_keys", keys, 32'h84002001);
    check32("scan2_valid_pulses", nv, 32'd1);
    check1("scan2_changed", chg, 1'b0);

    dev_data = 32'h12345678;
    run_scan(2, 800, lat, nv, chg, cap, gaps);
    check32("scan3_keys", keys, 32'h12345678);
    check32("scan3_valid_pulses", nv, 32'd1);
    check32("scan3_busy_gaps", gaps, 32'd0);
    check1("scan3_changed", chg, 1'b1);

    dev_data = 32'hFFFFFFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; bus_gnt = 1'b1;
    repeat (900) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check1("rst_tm_stb", tm_stb, 1'b1);
    check1("rst_tm_dio_oe", tm_dio_oe, 1'b0);
    check1("rst_tm_clk", tm_clk, 1'b1);
    check1("rst_bus_req", bus_req, 1'b0);
    check32("rst_keys", keys, 32'h0);
    bus_gnt = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    dev_data = 32'hA5C30F69;
    run_scan(3, 0, lat, nv, chg, cap, gaps);
    check32("scan4_keys", keys, 32'hA5C30F69);
    check32("scan4_valid_pulses", nv, 32'd1);
    check1("scan4_changed", chg, 1'b1);

    rises    = 0;
    prev_req = bus_req;
    repeat (3000) begin
      @(negedge clk);
      if (bus_req && !prev_req) rises++;
      prev_req = bus_req;
    end
    check32("no_autopoll_rises", rises, 32'd0);
`else
    dev_data = 32'h00FF00FF;
    prev_req = bus_req;
    for (int i = 101; i <= 7000; i++) begin
      @(negedge clk);
      if (bus_req && !prev_req) rise_at.push_back(i);
      prev_req = bus_req;
      bus_gnt  = bus_req;
    end
    bus_gnt = 1'b0;
    check32("poll_rise_count", rise_at.size(), 32'd3);
    foreach (rise_at[i]) check32("poll_rise_cycle", rise_at[i], POLL * (i + 1));
    check32("poll_keys", keys, 32'h00FF00FF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tm1638_keyscan.md
# tm1638_keyscan

Key-scan reader for the TM1638 display/keypad board: it issues the TM1638 "read key data" command (0x42) and shifts in the four key-scan bytes over the shared CLK/STB/DIO wires. The write-side display driver sends data the other way on those same wires, so this block requests the bus and drives the wires only while granted. The top level muxes its pins onto `tm1638_clk`/`tm1638_stb`/`tm1638_dio`. It runs in the 16 MHz `cpu_clk` domain and presents a 32-bit key image to the CPU-side logic.

## Interface
Parameters:
- `HALF_DIV`, 16 — `clk` cycles per TM1638 CLK half-period (16 → 500 kHz at 16 MHz); legal 2..255.
- `WAIT_HALVES`, 4 — half-periods of DIO turnaround between command and read (≥2 µs at default).
- `POLL_CYCLES`, 160000 — auto-poll interval in `clk` cycles (10 ms); used only with the macro.

Ports:
- `clk` in 1 — system clock (`cpu_clk`).
- `reset` in 1 — asynchronous, active-high; one clock domain (`clk`) only.
- `start` in 1 — single-cycle scan request.
- `bus_req` out 1 — requests the TM1638 pins.
- `bus_gnt` in 1 — pins granted; the arbiter holds it until `bus_req` falls.
- `tm_clk` out 1 — TM1638 CLK.
- `tm_stb` out 1 — TM1638 STB, active-low.
- `tm_dio_out` out 1 — DIO drive value.
- `tm_dio_oe` out 1 — DIO output enable, high = drive.
- `tm_dio_in` in 1 — DIO pin, already synchronised by the top level.
- `keys` out 32 — last completed scan; byte n in `keys[8n+7:8n]`.
- `keys_valid` out 1 — one-cycle pulse when `keys` updates.
- `keys_changed` out 1 — one-cycle pulse, coincident with `keys_valid`, when the new `keys` differs from the previous value.
- `busy` out 1 — high from request until return to IDLE.

## Operation
- Half-period tick: a counter runs 0..`HALF_DIV`-1 in every non-IDLE/non-REQ state and pulses at terminal count. All state/bit actions occur on ticks.
- IDLE: `start` (or the auto-poll tick) → REQ. A `start` received in any other state is dropped; no queueing.
- REQ: `bus_req`=1. When `bus_gnt`=1 → STB_LO and the tick counter clears. `bus_gnt` is sampled only in REQ.
- STB_LO: `tm_stb`=0, `tm_clk`=1, `tm_dio_oe`=1, for one half-period → CMD.
- CMD: 8 bits of 0x42, LSB first. On the falling half `tm_clk`=0 and `tm_dio_out`=bit; on the rising half `tm_clk`=1. After 16 half-periods → WAIT.
- WAIT: `tm_dio_oe`=0, `tm_clk`=1, for `WAIT_HALVES` half-periods → READ.
- READ: 32 bits. `tm_clk`=0 for one half-period, then `tm_clk`=1. `tm_dio_in` is sampled in the `clk` cycle where `tm_clk` rises and is shifted in LSB first, so bit k lands in `shift[k]`. After 64 half-periods → STB_HI.
- STB_HI: `tm_clk`=1, `tm_stb`=1, for one half-period → DONE.
- DONE (one cycle): `keys`←shift; `keys_valid`=1; `keys_changed`=(shift≠old `keys`); `bus_req`=0 → IDLE.
- Bit counters are 6 bits wide with no wrap: exactly 8 command bits and 32 read bits per scan.

## Timing
- Reset values: `bus_req`=0, `tm_clk`=1, `tm_stb`=1, `tm_dio_out`=1, `tm_dio_oe`=0, `keys`=0, `keys_valid`=0, `keys_changed`=0, `busy`=0, state IDLE.
- `start` → `bus_req`: 1 cycle (registered).
- Grant → `tm_stb` low: 1 cycle.
- Transaction length after grant: (1+16+`WAIT_HALVES`+64+1)·`HALF_DIV` cycles; 1376 at defaults. Then +1 cycle to DONE.
- `busy` falls in the cycle after DONE.
- Reset mid-transfer: all pins return to their idle levels immediately and `keys` is cleared. No partial result is published.

## Configuration
- `TM1638_KEYSCAN_AUTOPOLL_EN` defined: a free-running counter issues an internal start every `POLL_CYCLES` cycles. The counter keeps counting while busy, and a tick that lands while busy is dropped. `start` is ORed with the tick.
- Not defined: no counter is present, and scans occur only on `start`.

## Test plan
- Reset, then idle 100 cycles → all outputs hold their reset values; `bus_req`=0.
- `start` with `bus_gnt` held at 0 for 50 cycles, then raised → `tm_stb` stays 1 until the cycle after the grant. The DIO waveform then carries 0,1,0,0,0,0,1,0 (0x42 LSB first) on `tm_clk` rising edges.
- Device model returns bytes 0x01,0x20,0x00,0x84 → `keys`=0x84002001 and `keys_valid`/`keys_changed` pulse once. A repeat scan with the same data pulses `keys_valid` with `keys_changed`=0.
- `start` pulsed again during READ → ignored: exactly one DONE, and `busy` is continuous.
- `reset` asserted mid-READ → `tm_stb`=1 and `tm_dio_oe`=0 asynchronously, with `keys`=0. A fresh `start` completes normally.
- With the macro and `POLL_CYCLES`=2000, no `start` → `bus_req` rises every 2000 cycles. Without the macro → `bus_req` never rises.
